psk_symbol_mapper: RTL and testbench

Serialises a byte stream into PSK symbols and emits one Gray-coded phase index per symbol period. It sits directly downstream of the fixed-point sample counter. It observes the counter value and its enable to find symbol boundaries, and feeds the phase/carrier generation stage. It supports BPSK, QPSK and 8PSK, selectable at run time, with a valid/ready byte input and explicit underrun signalling.

---
 rtl/psk_symbol_mapper.sv | 56 +++++
 tb/tb_psk_symbol_mapper.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/psk_symbol_mapper.sv
// psk_symbol_mapper: serialises bytes into Gray-coded BPSK/QPSK/8PSK phase indices at counter boundaries
module psk_symbol_mapper (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctr_en,
  input  logic [15:0] ctr_in,
  input  logic [1:0]  mod_sel,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [2:0]  sym_phase,
  output logic        sym_valid,
  output logic        sym_strobe,
  output logic        underrun
);
  logic [15:0] buffer, base, nxt_buf;
  logic [4:0]  fill, rem, nxt_fill;
  logic [1:0]  k;
  logic [2:0]  g, ph;
  logic        boundary, pop, push;
  assign s_ready = rst_n && (fill <= 5'd8);
  always_comb begin
    k = mod_sel == 2'd1 ? 2'd2 : mod_sel == 2'd2 ? 2'd3 : 2'd1;
    boundary = ctr_en && (ctr_in == 16'h0000);
    pop = boundary && (fill >= {3'b000, k});
    push = s_valid && s_ready;
    base = pop ? buffer << k : buffer;
    rem = pop ? fill - {3'b000, k} : fill;
    nxt_buf = push ? base | ({s_data, 8'h00} >> rem) : base;
    nxt_fill = push ? rem + 5'd8 : rem;
    g = buffer[15:13];
    // Gray-to-binary on the leading bits, scaled to 45-degree units
    ph = mod_sel == 2'd1 ? {g[2], g[2] ^ g[1], 1'b0} :
         mod_sel == 2'd2 ? {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]} :
                           {g[2], 2'b00};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer <= '0;
      fill <= '0;
      sym_phase <= '0;
      sym_valid <= 1'b0;
      sym_strobe <= 1'b0;
      underrun <= 1'b0;
    end else begin
      buffer <= nxt_buf;
      fill <= nxt_fill;
      sym_strobe <= pop;
      underrun <= boundary && !pop;
      if (boundary) begin
        sym_phase <= pop ? ph : 3'd0;
        sym_valid <= pop;
      end
    end
  end
endmodule

// File: tb/tb_psk_symbol_mapper.sv
// tb_psk_symbol_mapper: directed self-checking bench for psk_symbol_mapper
module tb_psk_symbol_mapper;
  logic        clk = 1'b0;
  logic        rst_n, ctr_en, s_valid, s_ready, sym_valid, sym_strobe, underrun;
  logic [15:0] ctr_in;
  logic [1:0]  mod_sel;
  logic [7:0]  s_data;
  logic [2:0]  sym_phase;
  int n = 0;
  int errs = 0;

  psk_symbol_mapper dut (
    .clk(clk), .rst_n(rst_n), .ctr_en(ctr_en), .ctr_in(ctr_in), .mod_sel(mod_sel),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .sym_phase(sym_phase),
    .sym_valid(sym_valid), .sym_strobe(sym_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic boundary;
    ctr_en = 1'b1;
    ctr_in = 16'h0000;
    tick();
    ctr_in = 16'h0100;
  endtask

  task automatic sym(input string tag, input logic [2:0] ph);
    chk({tag, "_phase"}, {13'd0, sym_phase}, {13'd0, ph});
    chk({tag, "_strobe"}, {15'd0, sym_strobe}, 16'd1);
    chk({tag, "_valid"}, {15'd0, sym_valid}, 16'd1);
  endtask

  task automatic urun(input string tag);
    chk({tag, "_underrun"}, {15'd0, underrun}, 16'd1);
    chk({tag, "_strobe"}, {15'd0, sym_strobe}, 16'd0);
    chk({tag, "_valid"}, {15'd0, sym_valid}, 16'd0);
    chk({tag, "_phase"}, {13'd0, sym_phase}, 16'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    s_valid = 1'b0;
    ctr_en = 1'b0;
    ctr_in = 16'h0100;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    s_valid = 1'b1;
    s_data = d;
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] q_exp [4] = '{3'd0, 3'd2, 3'd4, 3'd6};
    logic [2:0] e_exp [5] = '{3'd6, 3'd6, 3'd7, 3'd6, 3'd4};
    logic [2:0] b_exp [8] = '{3'd4, 3'd0, 3'd4, 3'd0, 3'd0, 3'd4, 3'd0, 3'd4};
    logic [2:0] s_exp [7] = '{3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd0};
    rst_n = 1'b0;
    ctr_en = 1'b0;
    ctr_in = 16'h0100;
    mod_sel = 2'd0;
    s_data = 8'hFF;
    s_valid = 1'b1;
    tick(); tick(); tick();
    chk("rst_ready", {15'd0, s_ready}, 16'd0);
    chk("rst_valid", {15'd0, sym_valid}, 16'd0);
    chk("rst_phase", {13'd0, sym_phase}, 16'd0);
    chk("rst_strobe", {15'd0, sym_strobe}, 16'd0);
    chk("rst_underrun", {15'd0, underrun}, 16'd0);
    rst_n = 1'b1;
    s_valid = 1'b0;
    #1;
    chk("rel_ready", {15'd0, s_ready}, 16'd1);
    boundary();
    urun("rst_empty");
    ctr_en = 1'b0;
    tick();
    chk("urun_pulse", {15'd0, underrun}, 16'd0);

    mod_sel = 2'd1;
    push(8'h1E);
    for (int i = 0; i < 4; i++) begin
      boundary();
      sym($sformatf("qpsk%0d", i), q_exp[i]);
      tick();
      chk($sformatf("qpsk%0d_pulse", i), {15'd0, sym_strobe}, 16'd0);
      chk($sformatf("qpsk%0d_hold", i), {13'd0, sym_phase}, {13'd0, q_exp[i]});
      tick(); tick();
    end
    boundary();
    urun("qpsk_under");

    mod_sel = 2'd2;
    push(8'hB6);
    push(8'h5D);
    for (int i = 0; i < 5; i++) begin
      boundary();
      sym($sformatf("8psk%0d", i), e_exp[i]);
      tick();
    end
    boundary();
    urun("8psk_under");
    push(8'h00);
    boundary();
    sym("8psk_carry", 3'd7);

    do_reset();
    mod_sel = 2'd0;
    boundary();
    urun("reset_discard");

    do_reset();
    s_valid = 1'b1;
    s_data = 8'hA5;
    ctr_en = 1'b0;
    tick();
    chk("bp_ready8", {15'd0, s_ready}, 16'd1);
    tick();
    chk("bp_ready16", {15'd0, s_ready}, 16'd0);
    tick();
    chk("bp_hold", {15'd0, s_ready}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      boundary();
      sym($sformatf("bp%0d", i), b_exp[i]);
      chk($sformatf("bp%0d_ready", i), {15'd0, s_ready}, {15'd0, i == 7});
    end
    s_valid = 1'b0;

    do_reset();
    mod_sel = 2'd1;
    push(8'hFF);
    s_valid = 1'b1;
    s_data = 8'h00;
    boundary();
    s_valid = 1'b0;
    sym("simul", 3'd4);
    chk("simul_ready", {15'd0, s_ready}, 16'd0);
    for (int i = 0; i < 7; i++) begin
      boundary();
      sym($sformatf("simul%0d", i), s_exp[i]);
    end
    boundary();
    urun("simul_under");

    do_reset();
    mod_sel = 2'd0;
    push(8'h80);
    ctr_en = 1'b0;
    ctr_in = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("gate%0d_strobe", i), {15'd0, sym_strobe}, 16'd0);
      chk($sformatf("gate%0d_underrun", i), {15'd0, underrun}, 16'd0);
    end
    boundary();
    sym("mode_bpsk", 3'd4);
    tick();
    mod_sel = 2'd1;
    tick();
    boundary();
    sym("mode_qpsk", 3'd0);
    mod_sel = 2'd0;
    ctr_in = 16'h0000;
    tick();
    sym("stuck0", 3'd0);
    tick();
    sym("stuck1", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule
